// File: rtl/icache_mem_nway_if.sv
// Lookup, allocate and fill signals between the I-cache controller and the N-way storage array.
// Latency: lookup outputs are combinational; backpressure: alloc_stall refuses an allocation.
interface icache_mem_nway_if #(
    parameter int NUM_SETS = 32,
    parameter int NUM_WAYS = 4,
    parameter int TAG_W    = 8,
    parameter int BLOCK_W  = 64,
    parameter int MTAG_W   = 4
);
    localparam int IDX_W = $clog2(NUM_SETS);

    logic               rd_en;
    logic [IDX_W-1:0]   rd_index;
    logic [TAG_W-1:0]   rd_tag;
    logic               pf_en;
    logic [IDX_W-1:0]   pf_index;
    logic [TAG_W-1:0]   pf_tag;
    logic               alloc_en;
    logic [IDX_W-1:0]   alloc_index;
    logic [TAG_W-1:0]   alloc_tag;
    logic               alloc_demand;
    logic [MTAG_W-1:0]  mem_response;
    logic [MTAG_W-1:0]  mem_tag;
    logic [BLOCK_W-1:0] mem_data;
    logic               flush;
    logic               rd_valid;
    logic               rd_miss;
    logic [BLOCK_W-1:0] rd_data;
    logic               pf_miss;
    logic               alloc_stall;

    modport master (
        output rd_en, rd_index, rd_tag, pf_en, pf_index, pf_tag,
               alloc_en, alloc_index, alloc_tag, alloc_demand,
               mem_response, mem_tag, mem_data, flush,
        input  rd_valid, rd_miss, rd_data, pf_miss, alloc_stall
    );

    modport slave (
        input  rd_en, rd_index, rd_tag, pf_en, pf_index, pf_tag,
               alloc_en, alloc_index, alloc_tag, alloc_demand,
               mem_response, mem_tag, mem_data, flush,
        output rd_valid, rd_miss, rd_data, pf_miss, alloc_stall
    );
endinterface

// File: rtl/icache_mem_nway.sv
// N-way set-associative I-cache storage: demand/prefetch lookup, miss allocation, tagged fill with bypass.
// Latency: lookups combinational, state updates next edge; backpressure: alloc_stall when a set is all pending.
module icache_mem_nway #(
    parameter int NUM_SETS = 32,
    parameter int NUM_WAYS = 4,
    parameter int TAG_W    = 8,
    parameter int BLOCK_W  = 64,
    parameter int MTAG_W   = 4
) (
    input logic              clock,
    input logic              reset,
    icache_mem_nway_if.slave bus
);
    localparam int AGE_W = $clog2(NUM_WAYS);

    logic [NUM_WAYS-1:0] valid   [NUM_SETS];
    logic [NUM_WAYS-1:0] pending [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [MTAG_W-1:0]   mtag_q  [NUM_SETS][NUM_WAYS];
    logic [BLOCK_W-1:0]  data_q  [NUM_SETS][NUM_WAYS];
    logic [AGE_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];
    logic                demand_pend_v;
    logic [MTAG_W-1:0]   demand_pend_tag;

    logic               rd_hit;
    logic [AGE_W-1:0]   rd_way;
    logic [BLOCK_W-1:0] rd_hit_data;
    logic               pf_present;
    logic               alloc_dup;
    logic               free_found;
    logic [AGE_W-1:0]   free_way;
    logic               lru_found;
    logic [AGE_W-1:0]   lru_way;
    logic [AGE_W-1:0]   lru_age;
    logic [AGE_W-1:0]   victim;
    logic               alloc_fire;
    logic               alloc_wr;
    logic               fill_act;
    logic               bypass;
    logic               hit_touch;

    always_comb begin
        rd_hit      = 1'b0;
        rd_way      = '0;
        rd_hit_data = '0;
        pf_present  = 1'b0;
        alloc_dup   = 1'b0;
        free_found  = 1'b0;
        free_way    = '0;
        lru_found   = 1'b0;
        lru_way     = '0;
        lru_age     = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[bus.rd_index][w] && tag_q[bus.rd_index][w] == bus.rd_tag) begin
                rd_hit      = 1'b1;
                rd_way      = AGE_W'(w);
                rd_hit_data = data_q[bus.rd_index][w];
            end
            if ((valid[bus.pf_index][w] || pending[bus.pf_index][w]) &&
                tag_q[bus.pf_index][w] == bus.pf_tag)
                pf_present = 1'b1;
            if ((valid[bus.alloc_index][w] || pending[bus.alloc_index][w]) &&
                tag_q[bus.alloc_index][w] == bus.alloc_tag)
                alloc_dup = 1'b1;
            if (!free_found && !valid[bus.alloc_index][w] && !pending[bus.alloc_index][w]) begin
                free_found = 1'b1;
                free_way   = AGE_W'(w);
            end
            // Ages form a permutation per set, so the oldest non-pending way is unique.
            if (!pending[bus.alloc_index][w] &&
                (!lru_found || age_q[bus.alloc_index][w] > lru_age)) begin
                lru_found = 1'b1;
                lru_way   = AGE_W'(w);
                lru_age   = age_q[bus.alloc_index][w];
            end
        end
    end

    assign victim     = free_found ? free_way : lru_way;
    assign alloc_fire = bus.alloc_en && (bus.mem_response != '0);
    assign alloc_wr   = alloc_fire && !alloc_dup && lru_found;
    assign fill_act   = (bus.mem_tag != '0);
    assign bypass     = demand_pend_v && fill_act && (bus.mem_tag == demand_pend_tag);
    // An allocation in the same set owns the LRU update for that cycle.
    assign hit_touch  = bus.rd_en && rd_hit && !(alloc_wr && bus.alloc_index == bus.rd_index);

    assign bus.rd_valid    = bypass || (bus.rd_en && rd_hit);
    assign bus.rd_miss     = !bypass && bus.rd_en && !rd_hit;
    assign bus.rd_data     = bypass ? bus.mem_data : ((bus.rd_en && rd_hit) ? rd_hit_data : '0);
    assign bus.pf_miss     = bus.pf_en && !pf_present;
    assign bus.alloc_stall = alloc_fire && !alloc_dup && !lru_found;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s]   <= '0;
                pending[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    mtag_q[s][w] <= '0;
                    data_q[s][w] <= '0;
                    age_q[s][w]  <= AGE_W'(w);
                end
            end
            demand_pend_v   <= 1'b0;
            demand_pend_tag <= '0;
        end else if (bus.flush) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s]   <= '0;
                pending[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++)
                    mtag_q[s][w] <= '0;
            end
            demand_pend_v <= 1'b0;
        end else begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (fill_act && pending[s][w] && mtag_q[s][w] == bus.mem_tag) begin
                        data_q[s][w]  <= bus.mem_data;
                        valid[s][w]   <= 1'b1;
                        pending[s][w] <= 1'b0;
                        mtag_q[s][w]  <= '0;
                    end
                end
            end
            if (bypass)
                demand_pend_v <= 1'b0;
            if (hit_touch) begin
                for (int w = 0; w < NUM_WAYS; w++)
                    if (age_q[bus.rd_index][w] < age_q[bus.rd_index][rd_way])
                        age_q[bus.rd_index][w] <= age_q[bus.rd_index][w] + 1'b1;
                age_q[bus.rd_index][rd_way] <= '0;
            end
            // Victim is never pending, so it cannot collide with a fill above.
            if (alloc_wr) begin
                tag_q[bus.alloc_index][victim]   <= bus.alloc_tag;
                mtag_q[bus.alloc_index][victim]  <= bus.mem_response;
                pending[bus.alloc_index][victim] <= 1'b1;
                valid[bus.alloc_index][victim]   <= 1'b0;
                if (bus.alloc_demand) begin
                    demand_pend_v   <= 1'b1;
                    demand_pend_tag <= bus.mem_response;
                end
                for (int w = 0; w < NUM_WAYS; w++)
                    if (age_q[bus.alloc_index][w] < age_q[bus.alloc_index][victim])
                        age_q[bus.alloc_index][w] <= age_q[bus.alloc_index][w] + 1'b1;
                age_q[bus.alloc_index][victim] <= '0;
            end
        end
    end
endmodule

// File: doc/icache_mem_nway.md
# icache_mem_nway

Parametrised N-way set-associative instruction-cache storage array, successor to the 2-way I-cache memory. It sits between the I-cache controller and the memory interface. It performs same-cycle demand and prefetch tag lookups and allocates miss lines tagged with an outstanding memory transaction ID. It fills lines when the matching memory tag returns and bypasses returning demand data. New relative to the 2-way array: configurable set and way counts, true-LRU replacement by age counters, pending-aware victim selection, duplicate-allocation suppression and a global flush.

## Interface
- NUM_SETS, 32, number of sets (power of two); IDX_W = log2(NUM_SETS)
- NUM_WAYS, 4, associativity (power of two, ≥2); AGE_W = log2(NUM_WAYS)
- TAG_W, 8, address tag width
- BLOCK_W, 64, line data width
- MTAG_W, 4, memory transaction tag width; value 0 means "no transaction"

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-low (asserted at 0)
- rd_en  in  1  demand lookup enable
- rd_index  in  IDX_W  demand set index
- rd_tag  in  TAG_W  demand tag
- pf_en  in  1  prefetch lookup enable
- pf_index  in  IDX_W  prefetch set index
- pf_tag  in  TAG_W  prefetch tag
- alloc_en  in  1  allocate a miss line this cycle
- alloc_index  in  IDX_W  set to allocate
- alloc_tag  in  TAG_W  tag to allocate
- alloc_demand  in  1  allocation belongs to the demand stream
- mem_response  in  MTAG_W  transaction ID of the issued request; 0 means no request
- mem_tag  in  MTAG_W  ID of the returning fill; 0 means none
- mem_data  in  BLOCK_W  fill data
- flush  in  1  invalidate the whole array
- rd_valid  out  1  rd_data valid (hit or bypass)
- rd_miss  out  1  demand lookup missed
- rd_data  out  BLOCK_W  demand data
- pf_miss  out  1  prefetch lookup missed (line neither valid nor pending)
- alloc_stall  out  1  allocation refused: every way in the set is pending

## Operation
- Per line state: valid, pending, tag, mtag, data, age.
- Lookups are combinational on registered state. A hit requires a tag match with valid=1.
- Demand output priority:
  - First: bypass. demand_pend_v=1 and mem_tag==demand_pend_tag≠0 gives rd_valid=1, rd_data=mem_data, rd_miss=0, independent of rd_en.
  - Else rd_en with a hit gives rd_valid=1 and the hitting way's data.
  - Else rd_en gives rd_miss=1, rd_data=0.
  - With rd_en=0 and no bypass, all demand outputs are 0.
- pf_miss=1 iff pf_en and no way in pf_index matches pf_tag with valid or pending set.
- Allocation fires only when alloc_en=1 and mem_response≠0.
  - If alloc_tag already matches a valid or pending way in the set, no write occurs (duplicate suppressed) and alloc_stall=0.
  - Otherwise the victim is the lowest-index way with valid=0 and pending=0. Failing that, it is the non-pending way with the largest age.
  - If every way is pending, alloc_stall=1 and no state changes.
  - Victim write: tag=alloc_tag, mtag=mem_response, pending=1, valid=0.
  - If alloc_demand=1, the block also loads demand_pend_v=1 and demand_pend_tag=mem_response.
- Fill: every line with pending=1 and mtag==mem_tag≠0 gets data=mem_data, valid=1, pending=0, mtag=0. demand_pend_v clears when mem_tag matches demand_pend_tag.
- LRU touch of way w (age a): every way in the set with age<a increments by 1; w becomes 0. A demand hit touches the hit way; an allocation touches the victim. If both target the same set in one cycle, only the allocation touch is applied. Fills do not touch.
- Flush clears valid, pending, mtag and demand_pend_v in all sets. Ages and data are unchanged. Fills arriving after a flush are dropped.

## Timing
- All lookup outputs are combinational, same cycle. State updates occur at posedge clock.
- Same-cycle ordering:
  - flush overrides fill and alloc.
  - A fill is applied before an alloc. A way being filled this cycle still counts as pending for victim choice.
  - An alloc whose mem_response equals mem_tag is legal; it allocates normally and completes on a later return.
- Reset (asynchronous): valid, pending, mtag, tag, data and demand_pend cleared; age of way w = w in every set.
- Output values under reset: rd_valid=0, rd_data=0, alloc_stall=0. rd_miss=rd_en and pf_miss=pf_en (array empty).
- Reset asserted mid-miss drops all outstanding transactions; later matching fills are ignored.
- Miss-to-hit latency: the fill cycle delivers data via bypass. The line hits from the next cycle.

## Test plan
- Reset, then rd_en at index 3, tag 0x12 → rd_miss=1, rd_valid=0. Alloc with mem_response=5 and alloc_demand; mem_tag=5, mem_data=0xDEAD → bypass rd_valid=1, rd_data=0xDEAD that cycle; the following cycle a lookup of index 3, tag 0x12 hits with 0xDEAD.
- NUM_WAYS=4, set 0:
  - Fill tags A,B,C,D. Hit A → A becomes MRU. Allocate E → victim is B.
  - A lookup for B then misses, and pf_miss=1 for B.
- Four pending allocations to set 7 (mtags 1–4), then a fifth alloc → alloc_stall=1, no state change. Fill mtag 2 → the same alloc now succeeds, with way 1 as victim.
- Alloc of tag 0x12 (mtag 6), then re-alloc of 0x12 (mtag 7) → suppressed. A return of mtag 7 writes nothing. pf_miss=0 for 0x12 while pending.
- Flush with a pending demand (mtag 3), then mem_tag=3 → rd_valid=0 and no line becomes valid.
- reset=0 mid-transaction → all outputs take their reset values immediately (asynchronously). After release, the pre-reset mtag returns → ignored.
